dsp_mem_arbiter: RTL
====================

// Module: dsp_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing a single coefficient-memory port (memaddr/memdout) between NREQ dsp
//  instances. Serialises requests, one access in flight. Drives the memory port and returns read data
//  to the winning requester. Sits between the dsp instances and the shared coefficient RAM.
// PARAMETERS
//  NREQ     2   number of requesters, 2..8
//  AW       6   memory address width
//  DW       14  memory data width
//  MEM_LAT  1   cycles from the mem_en cycle until mem_rdata is valid, 1..4
// PORTS
//  clk         in   1        system clock; all logic on rising edge
//  rst         in   1        reset
//  req         in   NREQ     per-requester access request, held high until gnt
//  req_we      in   NREQ     per-requester write flag; 0 = read
//  req_addr    in   NREQ*AW  per-requester address; slice i = [i*AW +: AW]
//  req_wdata   in   NREQ*DW  per-requester write data; slice i = [i*DW +: DW]
//  gnt         out  NREQ     one-hot one-cycle pulse: the request is accepted
//  rsp_valid   out  NREQ     one-hot one-cycle pulse: rsp_data is valid for that requester
//  rsp_data    out  DW       read data, registered
//  mem_en      out  1        memory access strobe, one cycle per access
//  mem_we      out  1        memory write enable, qualified by mem_en
//  mem_addr    out  AW       memory address
//  mem_wdata   out  DW       memory write data
//  mem_rdata   in   DW       memory read data
//  busy        out  1        high whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-high.
//  - While rst is high: all outputs 0, state IDLE, last-winner pointer = NREQ-1 (requester 0 wins first).
//  - FSM states: IDLE -> ACCESS -> (write) IDLE | (read) WAIT -> RESP -> IDLE.
//  - IDLE: when |req is high at edge T, pick the winner, searching from last+1 upward with wrap.
//    Latch the winner's we/addr/wdata, update last = winner and go to ACCESS.
//  - ACCESS (cycle T+1): gnt[w]=1, mem_en=1, and mem_we/addr/wdata come from the latched values.
//  - Write: next state IDLE. No rsp_valid for writes.
//  - Read: go to WAIT. A counter runs MEM_LAT cycles and mem_rdata is captured on the last one.
//  - RESP: rsp_valid[w]=1 with the captured rsp_data for exactly one cycle, then IDLE.
//  - Read with MEM_LAT=1: req at T -> gnt and mem_en at T+1 -> rsp_valid at T+3. Next grant no earlier than T+4.
//  - Write: req at T -> gnt at T+1 -> next grant no earlier than T+3.
//  - Requests are sampled only in IDLE. A req dropped before gnt is ignored if not sampled.
//    Once sampled, the access is committed even if req falls.
//  - A requester re-asserting req in the gnt cycle is treated as a new request.
//  - All requesters requesting continuously: strict rotation 0,1,..,NREQ-1,0. No requester waits more than NREQ grants.
//  - rsp_data holds its last value between responses. mem_addr/mem_wdata are don't-care while mem_en=0 (driven 0).
//  - Reset mid-access: in-flight access abandoned, no gnt/rsp_valid issued, pointer reset.
// CONFIGURATION
//  DSP_ARB_STATS_EN defined:
//    adds output grant_cnt [NREQ*16]: one saturating 16-bit grant counter per requester.
//    Cleared by rst; increments in that requester's ACCESS cycle; holds at 16'hFFFF.
//  Not defined: port and counters absent, all other behaviour identical.
// STRUCTURE
//  - Package dsp_arb_pkg: FSM state enum (IDLE, ACCESS, WAIT, RESP), default AW/DW constants,
//    latency-counter width.
//  - Sub-module rr_pick: combinational round-robin picker (req, last -> one-hot winner + index).
//    Instantiated once.
//  - Remainder is a single-process FSM plus output registers.
// TESTING
//  1. Single read: NREQ=2, req[1]=1, addr=6'h05, mem holds 14'h1ABC -> gnt[1] at T+1, mem_addr=5, rsp_valid[1]+rsp_data=14'h1ABC at T+3.
//  2. Contention: req=2'b11 held, all reads -> gnt order 0,1,0,1; each rsp_valid goes to the matching requester.
//  3. Write: req[0], we=1, addr=6'h3F, wdata=14'h2AAA -> mem_en&mem_we at T+1 with those values, no rsp_valid, busy low at T+2.
//  4. Latency: MEM_LAT=3, single read -> rsp_valid exactly 4 cycles after gnt, data = mem_rdata at mem_en+3.
//  5. Reset mid-read: rst asserted during WAIT -> outputs 0 immediately, no rsp_valid; next req 3'b110 grants requester 1.
//  6. DSP_ARB_STATS_EN: 5 grants to req 0 -> grant_cnt[15:0]=5. Preload near 16'hFFFF -> saturates.

Source files
------------

// File: rtl/dsp_arb_pkg.sv
// Shared definitions for the coefficient-memory arbiter.
//   arb_state_e : FSM state encoding (IDLE, ACCESS, WAIT, RESP)
//   DEF_AW/DEF_DW : default memory address/data widths
//   LAT_CW      : width of the read-latency down-counter (MEM_LAT up to 4)
//   CNT_W       : width of one per-requester grant counter
//   sat_inc16   : saturating 16-bit increment used by the grant statistics
package dsp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int DEF_AW = 6;
    localparam int DEF_DW = 14;
    localparam int LAT_CW = 2;
    localparam int CNT_W  = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dsp_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting one position above the previous
// winner and wrapping around, so the previous winner has lowest priority.
//   req   in  NREQ  request vector
//   last  in  IW    index of the previous winner
//   grant out NREQ  one-hot winner (all zero when nothing requests)
//   idx   out IW    winner index (0 when nothing requests)
//   valid out 1     at least one request present
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    int cand_s;

    // First requester found on the rotating search from last+1 wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        grant  = '0;
        cand_s = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = (int'(last) + k) % NREQ;
            if (!valid && req[cand_s[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand_s[IW-1:0];
            end else begin
                valid = valid;
            end
        end
        if (valid) begin
            grant = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/dsp_mem_arbiter.sv
// Round-robin arbiter sharing one coefficient-memory port between NREQ DSP
// requesters, with one access in flight at a time.
// Optional feature macro: DSP_ARB_STATS_EN adds per-requester saturating
// 16-bit grant counters on output grant_cnt.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req/req_we               per-requester request and write flag
//   req_addr/req_wdata       per-requester address/data, slice i = [i*W +: W]
//   gnt                      one-hot pulse in the ACCESS cycle
//   rsp_valid/rsp_data       one-hot read response pulse + held read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   shared memory port
//   busy                     FSM not in IDLE
//   grant_cnt (stats only)   NREQ x 16-bit grant counters
module dsp_mem_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
`ifdef DSP_ARB_STATS_EN
    output logic               busy,
    output logic [NREQ*16-1:0] grant_cnt
`else
    output logic               busy
`endif
);

    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    arb_state_e          state_r;
    logic [IW-1:0]       last_r;
    logic [IW-1:0]       win_idx_r;
    logic                win_we_r;
    logic [LAT_CW-1:0]   lat_cnt_r;

    logic [NREQ-1:0]     pick_grant_s;
    logic [IW-1:0]       pick_idx_s;
    logic                pick_valid_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .last  (last_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Arbitration FSM; every output is registered here. Pulse outputs and the
    // memory address/data default to zero each cycle and are set only when due.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            last_r    <= IW'(NREQ - 1);
            win_idx_r <= '0;
            win_we_r  <= 1'b0;
            lat_cnt_r <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        // Winner's fields go straight onto the memory port for the ACCESS cycle.
                        state_r   <= ACCESS;
                        last_r    <= pick_idx_s;
                        win_idx_r <= pick_idx_s;
                        win_we_r  <= req_we[pick_idx_s];
                        gnt       <= pick_grant_s;
                        mem_en    <= 1'b1;
                        mem_we    <= req_we[pick_idx_s];
                        mem_addr  <= req_addr[int'(pick_idx_s)*AW +: AW];
                        mem_wdata <= req_wdata[int'(pick_idx_s)*DW +: DW];
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (win_we_r) begin
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        // Read data arrives MEM_LAT cycles after the strobe.
                        state_r   <= WAIT;
                        lat_cnt_r <= LAT_CW'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt_r == '0) begin
                        state_r   <= RESP;
                        rsp_data  <= mem_rdata;
                        rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_r;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_CW'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DSP_ARB_STATS_EN
    // Per-requester grant counters, bumped once per ACCESS cycle and saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (state_r == ACCESS) begin
            grant_cnt[int'(win_idx_r)*CNT_W +: CNT_W] <=
                sat_inc16(grant_cnt[int'(win_idx_r)*CNT_W +: CNT_W]);
        end else begin
            grant_cnt <= grant_cnt;
        end
    end
`else
    // Statistics build option disabled: no grant counters.
`endif

endmodule
